cpu_icache_direct: RTL

- Direct-mapped, one-word-per-line instruction cache between the instruction bus and the fetch stage.
- Fetch presents a PC. The cache returns the instruction word with a ready flag on a hit, or runs a single-word bus fill on a miss.
- Supports full invalidation, for fence.i and after reset.

---
 rtl/cpu_icache_direct.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cpu_icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with single-word bus fills
// and a full-array flush after reset or on invalidate.
module cpu_icache_direct #(
  parameter int INDEX_BITS = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_input_pc,
  input  logic        i_stall,
  input  logic        i_invalidate,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  localparam logic [INDEX_BITS-1:0] CNT_ONE  = INDEX_BITS'(1);
  localparam logic [INDEX_BITS-1:0] CNT_ZERO = INDEX_BITS'(0);
  localparam logic [INDEX_BITS-1:0] CNT_LAST = {INDEX_BITS{1'b1}};

  logic                  valid_q [LINES];
  logic [TAG_BITS-1:0]   tag_q   [LINES];
  logic [31:0]           data_q  [LINES];

  logic [1:0]            state_q,     state_d;
  logic [INDEX_BITS-1:0] flush_cnt_q, flush_cnt_d;
  logic [INDEX_BITS-1:0] fill_idx_q,  fill_idx_d;
  logic [TAG_BITS-1:0]   fill_tag_q,  fill_tag_d;
  logic                  inv_pend_q,  inv_pend_d;
  logic                  bus_req_q,   bus_req_d;
  logic [31:0]           bus_addr_q,  bus_addr_d;
  logic [31:0]           hit_cnt_q,   hit_cnt_d;
  logic [31:0]           miss_cnt_q,  miss_cnt_d;

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit_s;
  logic                  valid_clr_s;
  logic                  fill_wr_s;
  logic                  unused_s;

  assign idx_s    = i_input_pc[INDEX_BITS+1:2];
  assign tag_s    = i_input_pc[31:INDEX_BITS+2];
  assign unused_s = ^i_input_pc[1:0];

  // Lookup is purely combinational so a hit costs no extra cycle.
  assign hit_s   = (state_q == ST_IDLE) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign o_ready = hit_s;
  assign o_rdata = data_q[idx_s];

  assign valid_clr_s = (state_q == ST_FLUSH);
  assign fill_wr_s   = (state_q == ST_FILL) && i_bus_ready;

  assign o_bus_request = bus_req_q;
  assign o_bus_address = bus_addr_q;
  assign o_hit_count   = hit_cnt_q;
  assign o_miss_count  = miss_cnt_q;

  // Array storage has no reset; the FLUSH sweep establishes the valid bits.
  always_ff @(posedge i_clock) begin
    if (valid_clr_s) begin
      valid_q[flush_cnt_q] <= 1'b0;
    end else if (fill_wr_s) begin
      valid_q[fill_idx_q] <= 1'b1;
    end
    if (fill_wr_s) begin
      tag_q[fill_idx_q]  <= fill_tag_q;
      data_q[fill_idx_q] <= i_bus_rdata;
    end
  end

  // Next-state logic for the FLUSH / IDLE / FILL controller.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    fill_idx_d  = fill_idx_q;
    fill_tag_d  = fill_tag_q;
    inv_pend_d  = inv_pend_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
        inv_pend_d  = 1'b0;
        bus_req_d   = 1'b0;
        if (flush_cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_IDLE: begin
        if (i_invalidate) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = CNT_ZERO;
        end else if (!i_stall && hit_s) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (!i_stall) begin
          state_d    = ST_FILL;
          fill_idx_d = idx_s;
          fill_tag_d = tag_s;
          bus_addr_d = {i_input_pc[31:2], 2'b00};
          bus_req_d  = 1'b1;
          miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (i_invalidate) begin
          inv_pend_d = 1'b1;
        end else begin
          inv_pend_d = inv_pend_q;
        end
        // An invalidate seen during the fill turns completion into a flush.
        if (i_bus_ready) begin
          bus_req_d = 1'b0;
          if (inv_pend_q || i_invalidate) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = CNT_ZERO;
            inv_pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d     = ST_FLUSH;
        flush_cnt_d = CNT_ZERO;
        bus_req_d   = 1'b0;
      end
    endcase
  end

  // Control and counter registers; reset abandons any in-flight fill.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= CNT_ZERO;
      fill_idx_q  <= CNT_ZERO;
      fill_tag_q  <= {TAG_BITS{1'b0}};
      inv_pend_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= 32'd0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fill_idx_q  <= fill_idx_d;
      fill_tag_q  <= fill_tag_d;
      inv_pend_q  <= inv_pend_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

endmodule
